// File: rtl/emif_calbus_pkg.sv
// rtl/emif_calbus_pkg.sv - shared types and constants for the EMIF calibration bus responder
package emif_calbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } cal_state_e;

   localparam int TBL_WORDS = 128;

   localparam logic [1:0] CSR_CTRL    = 2'd0;
   localparam logic [1:0] CSR_STATUS  = 2'd1;
   localparam logic [1:0] CSR_SCRATCH = 2'd2;
   localparam logic [1:0] CSR_ERRCNT  = 2'd3;

   localparam int STS_CAL_REQ    = 0;
   localparam int STS_SUCCESS    = 1;
   localparam int STS_FAIL       = 2;
   localparam int STS_ERRCNT_LSB = 8;

endpackage

// File: rtl/emif_calbus_rd_pipe.sv
// rtl/emif_calbus_rd_pipe.sv - read-data delay line; output holds the last retired word
module emif_calbus_rd_pipe #(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        vld_i,
   input  logic [31:0] data_i,
   output logic [31:0] rdata_o
);

   logic        ret_vld;
   logic [31:0] ret_data;
   logic [31:0] rdata_q;

   // The output register is the last stage, so only RD_LATENCY-1 extra stages sit in front of it.
   if (RD_LATENCY == 1) begin : g_direct
      assign ret_vld  = vld_i;
      assign ret_data = data_i;
   end else begin : g_stages
      logic        vld_q [RD_LATENCY-1];
      logic [31:0] dat_q [RD_LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 0; k < RD_LATENCY - 1; k++) begin
               vld_q[k] <= 1'b0;
               dat_q[k] <= '0;
            end
         end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= data_i;
            for (int k = 1; k < RD_LATENCY - 1; k++) begin
               vld_q[k] <= vld_q[k-1];
               dat_q[k] <= dat_q[k-1];
            end
         end
      end

      assign ret_vld  = vld_q[RD_LATENCY-2];
      assign ret_data = dat_q[RD_LATENCY-2];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (ret_vld) begin
         rdata_q <= ret_data;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/emif_calbus_responder.sv
// rtl/emif_calbus_responder.sv - calbus target: parameter table, CSRs, error counter, cal handshake FSM
module emif_calbus_responder
   import emif_calbus_pkg::*;
#(
   parameter int          RD_LATENCY    = 1,
   parameter logic [31:0] TIMEOUT_CYC   = 32'h0010_0000,
   parameter logic [19:0] CSR_BASE      = 20'h01000,
   parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
   input  logic          calbus_clk,
   input  logic          calbus_reset_n,
   input  logic          calbus_read_0,
   input  logic          calbus_write_0,
   input  logic [19:0]   calbus_address_0,
   input  logic [31:0]   calbus_wdata_0,
   output logic [31:0]   calbus_rdata_0,
   output logic [4095:0] calbus_seq_param_tbl_0,
   input  logic          cal_start,
   output logic          cal_busy,
   output logic          cal_success,
   output logic          cal_fail
);

   cal_state_e  state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] tbl_q [TBL_WORDS];
   logic [31:0] scratch_q;
   logic [15:0] errcnt_q, errcnt_d;
   logic        busy_d, success_d, fail_d;

   logic        rd_conflict, is_tbl, is_csr, mapped, err_evt, wr_ok;
   logic        ctrl_wr, errcnt_clr;
   logic [1:0]  csr_off;
   logic [31:0] rd_word;

   assign rd_conflict = calbus_read_0 & calbus_write_0;
   assign is_tbl      = (calbus_address_0[19:7] == 13'd0);
   assign is_csr      = (calbus_address_0[19:2] == CSR_BASE[19:2]);
   assign mapped      = is_tbl | is_csr;
   assign csr_off     = calbus_address_0[1:0];
   assign wr_ok       = calbus_write_0 & ~calbus_read_0;
   assign err_evt     = rd_conflict | ((calbus_read_0 | calbus_write_0) & ~mapped);
   assign ctrl_wr     = wr_ok & is_csr & (csr_off == CSR_CTRL);
   // A conflicting read+write aimed at ERRCNT still clears it, so the clear beats that cycle's error.
   assign errcnt_clr  = calbus_write_0 & is_csr & (csr_off == CSR_ERRCNT);

   always_comb begin
      rd_word = DEFAULT_RDATA;
      if (!rd_conflict) begin
         if (is_tbl) begin
            rd_word = tbl_q[calbus_address_0[6:0]];
         end else if (is_csr) begin
            case (csr_off)
               CSR_CTRL:    rd_word = '0;
               CSR_STATUS: begin
                  rd_word                         = '0;
                  rd_word[STS_CAL_REQ]            = (state_q == REQ);
                  rd_word[STS_SUCCESS]            = (state_q == DONE);
                  rd_word[STS_FAIL]               = (state_q == FAIL);
                  rd_word[STS_ERRCNT_LSB +: 8]    = errcnt_q[7:0];
               end
               CSR_SCRATCH: rd_word = scratch_q;
               default:     rd_word = {16'h0000, errcnt_q};
            endcase
         end
      end
   end

   always_comb begin
      errcnt_d = errcnt_q;
      if (errcnt_clr) begin
         errcnt_d = '0;
      end else if (err_evt && (errcnt_q != 16'hFFFF)) begin
         errcnt_d = errcnt_q + 16'd1;
      end
   end

   always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
      if (!calbus_reset_n) begin
         for (int i = 0; i < TBL_WORDS; i++) begin
            tbl_q[i] <= '0;
         end
         scratch_q <= '0;
         errcnt_q  <= '0;
         timer_q   <= '0;
      end else begin
         if (wr_ok && is_tbl) begin
            tbl_q[calbus_address_0[6:0]] <= calbus_wdata_0;
         end
         if (wr_ok && is_csr && (csr_off == CSR_SCRATCH)) begin
            scratch_q <= calbus_wdata_0;
         end
         errcnt_q <= errcnt_d;
         timer_q  <= timer_d;
      end
   end

   for (genvar g = 0; g < TBL_WORDS; g++) begin : g_tbl_out
      assign calbus_seq_param_tbl_0[32*g +: 32] = tbl_q[g];
   end

   emif_calbus_rd_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk_i   (calbus_clk),
      .rst_ni  (calbus_reset_n),
      .vld_i   (calbus_read_0),
      .data_i  (rd_word),
      .rdata_o (calbus_rdata_0)
   );

   // Flags are registered from the next state so they line up with state_q.
   always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
      if (!calbus_reset_n) begin
         state_q     <= IDLE;
         cal_busy    <= 1'b0;
         cal_success <= 1'b0;
         cal_fail    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cal_busy    <= busy_d;
         cal_success <= success_d;
         cal_fail    <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (cal_start) begin
               state_d = REQ;
               timer_d = '0;
            end
         end
         REQ: begin
            timer_d = timer_q + 32'd1;
            if (ctrl_wr && calbus_wdata_0[1]) begin
               state_d = FAIL;
            end else if (ctrl_wr && (calbus_wdata_0[1:0] == 2'b01)) begin
               state_d = DONE;
            end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
               state_d = FAIL;
            end
         end
         default: begin
            if (!cal_start) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      busy_d    = (state_d == REQ);
      success_d = (state_d == DONE);
      fail_d    = (state_d == FAIL);
   end

endmodule

// File: tb/tb_emif_calbus_responder.sv
// tb/tb_emif_calbus_responder.sv - directed self-checking bench for emif_calbus_responder
module tb_emif_calbus_responder;

   localparam int          LAT  = 2;
   localparam logic [31:0] TOUT = 32'd16;
   localparam logic [31:0] DEF  = 32'hDEAD_BEEF;
   localparam logic [19:0] A_CTRL    = 20'h01000;
   localparam logic [19:0] A_STATUS  = 20'h01001;
   localparam logic [19:0] A_SCRATCH = 20'h01002;
   localparam logic [19:0] A_ERRCNT  = 20'h01003;
   localparam logic [19:0] A_UNMAP   = 20'h02000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd = 1'b0;
   logic          wr = 1'b0;
   logic [19:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic [4095:0] tbl;
   logic          cal_start = 1'b0;
   logic          busy, success, fail;
   logic [2:0]    flags;
   logic [31:0]   got;

   int n_chk  = 0;
   int n_pass = 0;

   assign flags = {busy, success, fail};

   always #5 clk = ~clk;

   emif_calbus_responder #(
      .RD_LATENCY    (LAT),
      .TIMEOUT_CYC   (TOUT),
      .CSR_BASE      (20'h01000),
      .DEFAULT_RDATA (DEF)
   ) dut (
      .calbus_clk             (clk),
      .calbus_reset_n         (rst_n),
      .calbus_read_0          (rd),
      .calbus_write_0         (wr),
      .calbus_address_0       (addr),
      .calbus_wdata_0         (wdata),
      .calbus_rdata_0         (rdata),
      .calbus_seq_param_tbl_0 (tbl),
      .cal_start              (cal_start),
      .cal_busy               (busy),
      .cal_success            (success),
      .cal_fail               (fail)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
      wr = 1'b1; addr = a; wdata = d;
      step();
      wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [19:0] a, output logic [31:0] d);
      rd = 1'b1; addr = a;
      step();
      rd = 1'b0;
      repeat (LAT - 1) step();
      d = rdata;
   endtask

   initial begin
      step(); step();
      chk("rst_flags", {29'd0, flags}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_tbl_zero", {31'd0, |tbl}, 32'd0);
      rst_n = 1'b1;
      step();

      bus_rd(A_STATUS, got);
      chk("rst_status", got, 32'h0);

      // table write then immediate read, with latency check
      bus_wr(20'h00005, 32'hA5A5_0001);
      chk("tbl5_bits", tbl[191:160], 32'hA5A5_0001);
      rd = 1'b1; addr = 20'h00005;
      step();
      rd = 1'b0;
      chk("rd_not_early", rdata, 32'h0);
      step();
      chk("rd_tbl5", rdata, 32'hA5A5_0001);

      bus_rd(A_UNMAP, got);
      chk("rd_unmapped", got, DEF);
      bus_rd(A_ERRCNT, got);
      chk("errcnt_1", got, 32'd1);

      rd = 1'b1; wr = 1'b1; addr = 20'h00005; wdata = 32'h0000_1234;
      step();
      rd = 1'b0; wr = 1'b0;
      repeat (LAT - 1) step();
      chk("conflict_rdata", rdata, DEF);
      chk("conflict_tbl", tbl[191:160], 32'hA5A5_0001);
      bus_rd(A_ERRCNT, got);
      chk("errcnt_2", got, 32'd2);
      bus_rd(A_STATUS, got);
      chk("status_errcnt", got, 32'h0000_0200);

      bus_wr(A_ERRCNT, 32'h0);
      bus_rd(A_ERRCNT, got);
      chk("errcnt_clr", got, 32'd0);

      bus_wr(A_SCRATCH, 32'hCAFE_F00D);
      bus_rd(A_SCRATCH, got);
      chk("scratch", got, 32'hCAFE_F00D);
      bus_rd(A_CTRL, got);
      chk("ctrl_reads0", got, 32'h0);
      bus_rd(A_ERRCNT, got);
      chk("ctrl_rd_noerr", got, 32'd0);

      // back-to-back reads
      bus_wr(20'h00006, 32'h0000_0066);
      rd = 1'b1; addr = 20'h00005;
      step();
      addr = 20'h00006;
      step();
      rd = 1'b0;
      chk("b2b_first", rdata, 32'hA5A5_0001);
      step();
      chk("b2b_second", rdata, 32'h0000_0066);
      step();
      chk("b2b_hold", rdata, 32'h0000_0066);

      // CTRL write outside REQ is ignored
      bus_wr(A_CTRL, 32'h1);
      chk("ctrl_idle_ign", {29'd0, flags}, 32'd0);

      // handshake to DONE
      cal_start = 1'b1;
      step();
      chk("req_busy", {29'd0, flags}, 32'b100);
      bus_rd(A_STATUS, got);
      chk("status_req", got, 32'h1);
      bus_wr(A_CTRL, 32'h1);
      chk("done_flags", {29'd0, flags}, 32'b010);
      bus_rd(A_STATUS, got);
      chk("status_done", got, 32'h2);
      cal_start = 1'b0;
      step();
      chk("done_to_idle", {29'd0, flags}, 32'b000);

      // handshake to FAIL via CTRL
      cal_start = 1'b1;
      step();
      bus_wr(A_CTRL, 32'h3);
      chk("ctrl_fail", {29'd0, flags}, 32'b001);
      cal_start = 1'b0;
      step();
      chk("fail_to_idle", {29'd0, flags}, 32'b000);

      // timeout
      cal_start = 1'b1;
      step();
      repeat (15) step();
      chk("tout_pre", {29'd0, flags}, 32'b100);
      step();
      chk("tout_fail", {29'd0, flags}, 32'b001);
      bus_wr(A_CTRL, 32'h1);
      chk("fail_hold", {29'd0, flags}, 32'b001);
      cal_start = 1'b0;
      step();
      chk("tout_idle", {29'd0, flags}, 32'b000);

      // saturation of ERRCNT, then clear beating a simultaneous error
      rd = 1'b1; wr = 1'b1; addr = A_UNMAP;
      repeat (65540) step();
      rd = 1'b0; wr = 1'b0;
      bus_rd(A_ERRCNT, got);
      chk("errcnt_sat", got, 32'h0000_FFFF);
      bus_rd(A_STATUS, got);
      chk("status_sat", got, 32'h0000_FF00);
      rd = 1'b1; wr = 1'b1; addr = A_ERRCNT;
      step();
      rd = 1'b0; wr = 1'b0;
      bus_rd(A_ERRCNT, got);
      chk("clr_wins", got, 32'd0);

      // async reset mid-REQ with a read in flight
      bus_rd(20'h00005, got);
      chk("pre_rst_rd", got, 32'hA5A5_0001);
      cal_start = 1'b1;
      step();
      rd = 1'b1; addr = 20'h00005;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_flags", {29'd0, flags}, 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      rd = 1'b0; cal_start = 1'b0;
      step();
      rst_n = 1'b1;
      step(); step(); step();
      chk("post_rst_rdata", rdata, 32'd0);
      chk("post_rst_flags", {29'd0, flags}, 32'd0);
      chk("post_rst_tbl", {31'd0, |tbl}, 32'd0);
      bus_rd(A_ERRCNT, got);
      chk("post_rst_errcnt", got, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
